// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared state encodings and width-legality helper for the
//                bit-serial add/subtract sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 32;

    // True when an operand width can be sequenced by the controller.
    function automatic bit width_is_legal(input int w);
        return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder (sum and carry-out of a + b + cin).
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Pure combinational one-bit add.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract sequencer. Operands enter over a
//                valid/ready handshake, are fed LSB-first through a single
//                full_adder with a registered carry, and the result, carry
//                and signed-overflow flag leave over a second handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    // Reject out-of-range widths at elaboration time.
    generate
        if (!width_is_legal(WIDTH)) begin : g_width_check
            $error("serial_add_ctrl: WIDTH must be in 2..32");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_carry_msb;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_sum;
    logic               w_cout;
    logic               w_cnt_msb_in;
    logic               w_cnt_last;

    // The single arithmetic element: current LSBs plus the held carry.
    full_adder u_full_adder (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Counter decodes: second-to-last bit yields the carry into the MSB,
    // last bit yields the final carry.
    always_comb begin
        w_cnt_msb_in = (r_cnt == CNT_W'(WIDTH - 2));
        w_cnt_last   = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Sequencer: accept, shift one bit per cycle, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1; op_cin is irrelevant then.
                        r_a_sh     <= op_a;
                        r_b_sh     <= op_sub ? ~op_b : op_b;
                        r_carry    <= op_cin | op_sub;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_cnt_msb_in) begin
                        r_carry_msb <= w_cout;
                    end
                    if (w_cnt_last) begin
                        r_cout      <= w_cout;
                        r_ovf       <= r_carry_msb ^ w_cout;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result registers are only written in RUN, so they stay
                    // stable for as long as the consumer stalls.
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs straight to the ports.
    always_comb begin
        in_ready  = r_in_ready;
        out_valid = r_out_valid;
        busy      = r_busy;
        result    = r_result;
        cout      = r_cout;
        ovf       = r_ovf;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single instance of the existing one-bit full_adder. It accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the full_adder, one bit per clock, with the carry held in a register. It returns the WIDTH-bit result, carry-out and signed-overflow flag over a second valid/ready handshake. It is the area-minimal arithmetic path for control logic that does not need single-cycle adds.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand request.
in_ready  output  1  controller can accept; high only in IDLE.
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
op_cin  input  1  carry-in; ignored when op_sub=1.
op_sub  input  1  1 = compute A-B (B inverted, carry-in forced to 1).
out_valid  output  1  result available; high only in DONE.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  sum/difference.
cout  output  1  final carry; for subtract, 1 = no borrow.
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock, clk; rst is sampled only on a rising edge.
- Reset state: IDLE. result=0, cout=0, ovf=0, carry register=0, counter=0, shift registers=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset.
- State machine ST_IDLE, ST_RUN, ST_DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load a_sh=op_a;
  - load b_sh=op_b, or ~op_b when op_sub=1;
  - load carry=op_cin|op_sub;
  - clear counter;
  - go to RUN.
- RUN, one bit per cycle:
  - full_adder inputs are a=a_sh[0], b=b_sh[0], cin=carry.
  - On each edge: shift a_sh and b_sh right; shift sum into result from the MSB side (result <= {sum, result[WIDTH-1:1]}); carry<=cout of the adder; counter+1.
  - On the edge where counter==WIDTH-2: capture carry-in-to-MSB, which is the adder cout at that edge.
  - On the edge where counter==WIDTH-1: write cout and ovf, go to DONE.
- DONE: out_valid=1. result, cout and ovf are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE. out_valid drops the next cycle.
- Latency: if the accept edge is edge k, out_valid is first high in the cycle after edge k+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles (WIDTH RUN, at least 1 DONE, 1 IDLE).
- result during RUN is a partial shift value and is meaningful only while out_valid=1. result, cout and ovf are not cleared on return to IDLE.
- in_valid while in RUN or DONE is ignored; in_ready=0 there. The upstream holds its request per the valid/ready protocol.
- op_* are sampled only on the accept edge. Later changes have no effect.
- rst in any state: next cycle is IDLE with all reset values. An in-flight operation is discarded with no out_valid pulse. rst has priority over a simultaneous in_valid or out_ready.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package serial_add_pkg holds the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 and WIDTH legality checks.
- Sub-module: one full_adder instance, used unchanged. All sequencing stays in serial_add_ctrl.

Test Plan (WIDTH=8):
1. op_a=0x35, op_b=0x4A, op_cin=0, op_sub=0 -> result=0x7F, cout=0, ovf=0. out_valid rises exactly 8 edges after the accept edge.
2. op_a=0xFF, op_b=0x01, op_cin=0 -> result=0x00, cout=1, ovf=0. Then op_a=0x00, op_b=0x00, op_cin=1 -> result=0x01, cout=0.
3. op_a=0x7F, op_b=0x01, op_cin=0 -> result=0x80, cout=0, ovf=1. Then op_a=0x80, op_b=0x80 -> result=0x00, cout=1, ovf=1.
4. Subtract: op_a=0x05, op_b=0x07, op_sub=1 -> result=0xFE, cout=0, ovf=0. op_a=0x80, op_b=0x01, op_sub=1 -> result=0x7F, cout=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, result, cout and ovf stay constant, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE next cycle, then the next op is accepted and correct.
6. Assert rst for one cycle at RUN bit 3 of 0xFF+0x01 -> next cycle in_ready=1, out_valid=0, result=0. Then 0x01+0x01 -> result=0x02, cout=0, proving no stale carry.
